// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
//  Module   : psum_drain
//  Purpose  : Drains the partial sums of one PE column. Shifts the column one
//             PE per cycle through o_psum_out_en, requantises each 16-bit
//             psum to signed DATA_WIDTH (round-half-up arithmetic shift with
//             saturation), packs PACK lanes per word and hands each word to
//             the ofmap buffer writer over valid/ready.
//  Ports    : i_clk, i_nrst (async, active-low)
//             i_start       - pulse, begin a drain (accepted only when idle)
//             i_shift_amt   - requant right-shift, latched on accepted start
//             i_psum        - chain-head psum (combinational view)
//             o_psum_out_en - shift enable to every PE in the column
//             o_busy        - accepted start until o_done
//             o_done        - 1-cycle pulse after the final word transfer
//             o_data        - packed word, lane 0 in the LSBs
//             o_valid/i_ready - word handshake, transfer = o_valid & i_ready
//  Revision : 1.0 - initial release
// ============================================================================
module psum_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PE     = 4,
    parameter int PACK       = 4
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_start,
    input  logic [3:0]                 i_shift_amt,
    input  logic [2*DATA_WIDTH-1:0]    i_psum,
    output logic                       o_psum_out_en,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [DATA_WIDTH*PACK-1:0] o_data,
    output logic                       o_valid,
    input  logic                       i_ready
);

    localparam int PW     = 2 * DATA_WIDTH;
    localparam int WW     = DATA_WIDTH * PACK;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CNT_W  = $clog2(NUM_PE + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_PE - 1);
    localparam logic signed [PW:0] SAT_MAX  = (PW + 1)'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PW:0] SAT_MIN  = -SAT_MAX - (PW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LANE_W-1:0]       r_lane;
    logic [CNT_W-1:0]        r_cnt;
    logic [3:0]              r_shift;
    logic [DATA_WIDTH-1:0]   r_lanes [PACK];
    logic [WW-1:0]           r_data;
    logic                    r_valid;
    logic                    r_done;

    logic                    w_xfer;
    logic                    w_data_free;
    logic                    w_last_lane;
    logic                    w_cap;
    logic                    w_load_full;
    logic                    w_load_part;
    logic                    w_done_nxt;
    logic [WW-1:0]           w_stage_word;
    logic [WW-1:0]           w_full_word;

    // ---------------- requantisation (one extra bit so the rounding add cannot overflow)
    logic signed [PW:0]      w_ext;
    logic signed [PW:0]      w_rnd;
    logic signed [PW:0]      w_sum;
    logic signed [PW:0]      w_shr;
    logic [DATA_WIDTH-1:0]   w_q;

    assign w_ext = {i_psum[PW-1], i_psum};
    assign w_rnd = (r_shift == 4'd0) ? '0 : ((PW + 1)'(1) <<< (r_shift - 4'd1));
    assign w_sum = w_ext + w_rnd;
    assign w_shr = w_sum >>> r_shift;

    always_comb begin
        w_q = w_shr[DATA_WIDTH-1:0];
        if (w_shr > SAT_MAX) begin
            w_q = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shr < SAT_MIN) begin
            w_q = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // ---------------- control
    assign w_xfer      = r_valid & i_ready;
    assign w_data_free = ~r_valid | i_ready;
    assign w_last_lane = (r_lane == LAST_LANE);

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_load_part = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Only a full lane set with a blocked output word stalls the column.
                w_cap = !(r_valid && !i_ready && w_last_lane);
                if (w_cap && (r_cnt == LAST_CNT)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // A non-zero lane index means a partial word is still staged.
                w_load_part = (r_lane != '0) && w_data_free;
                if ((r_lane == '0) && w_xfer) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_load_full = w_cap & w_last_lane;

    // Staged lanes as a word; the full word takes the psum captured this cycle as the top lane.
    always_comb begin
        w_stage_word = '0;
        for (int i = 0; i < PACK; i++) begin
            w_stage_word[i*DATA_WIDTH +: DATA_WIDTH] = r_lanes[i];
        end
        w_full_word = w_stage_word;
        w_full_word[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = w_q;
    end

    // ---------------- state register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- datapath registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_lane  <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < PACK; i++) begin
                r_lanes[i] <= '0;
            end
        end else begin
            r_done <= w_done_nxt;

            if ((r_state == S_IDLE) && i_start) begin
                r_shift <= i_shift_amt;
                r_cnt   <= '0;
                r_lane  <= '0;
            end

            if (w_cap) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last_lane) begin
                    // Word leaves for o_data; clear staging so a later partial word pads with 0.
                    r_lane <= '0;
                    for (int i = 0; i < PACK; i++) begin
                        r_lanes[i] <= '0;
                    end
                end else begin
                    r_lanes[r_lane] <= w_q;
                    r_lane          <= r_lane + LANE_W'(1);
                end
            end

            if (w_load_part) begin
                r_lane <= '0;
                for (int i = 0; i < PACK; i++) begin
                    r_lanes[i] <= '0;
                end
            end

            if (w_load_full) begin
                r_data <= w_full_word;
            end else if (w_load_part) begin
                r_data <= w_stage_word;
            end

            if (w_load_full || w_load_part) begin
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_psum_out_en = w_cap;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_data        = r_data;
    assign o_valid       = r_valid;

endmodule
`default_nettype wire
